mbus_tx_arbiter: RTL and testbench
==================================

# mbus_tx_arbiter

Layer-side scheduler sharing a single MBus regular node's TX port between up to `NUM_REQ` local requesters (layer controller, interrupt handler, DMA-style engines). Grants one requester at a time with priority-then-round-robin selection. Owns the grant for the whole message, including multi-word `TX_PEND` bursts. Relays the node's 4-phase word handshake and the `TX_SUCC`/`TX_FAIL`/`TX_RESP_ACK` completion handshake to the owner only.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `OWNER_WIDTH`, 2: width of `OWNER`; must equal ceil(log2(`NUM_REQ`)).
- `CLKIN` in 1: clock; all state updates on rising edge.
- `RESETn` in 1: asynchronous, active-low reset.
- `REQ_ADDR` in `NUM_REQ`*`ADDR_WIDTH`: per-requester address; requester i occupies slice i.
- `REQ_DATA` in `NUM_REQ`*`DATA_WIDTH`: per-requester data word.
- `REQ_PEND` in `NUM_REQ`: more words follow this one.
- `REQ_TX` in `NUM_REQ`: per-requester word request, level, 4-phase.
- `REQ_PRIORITY` in `NUM_REQ`: requester asks for priority arbitration.
- `REQ_ACK` out `NUM_REQ`: word accepted, one-hot or zero.
- `REQ_SUCC`, `REQ_FAIL` out `NUM_REQ`: message completion status, one-hot or zero.
- `REQ_RESP_ACK` in `NUM_REQ`: requester has consumed the status.
- `TX_ADDR` out `ADDR_WIDTH`, `TX_DATA` out `DATA_WIDTH`, `TX_PEND` out 1, `TX_REQ` out 1, `PRIORITY` out 1: to the node.
- `TX_ACK`, `TX_SUCC`, `TX_FAIL` in 1: from the node.
- `TX_RESP_ACK` out 1: to the node.
- `BUSY` out 1: a message is in progress.
- `OWNER` out `OWNER_WIDTH`: current or last grantee.

## Operation
- Reset values:
  - All outputs are 0.
  - Internal last-grant pointer is `NUM_REQ`-1, so requester 0 wins the first tie.
- FSM states: `IDLE`, `WREQ`, `WACK`, `WNEXT`, `WRESP`, `WDONE`.
- `IDLE`:
  - If any `REQ_TX` is high, pick the winner.
  - Selection: among requesters with `REQ_PRIORITY` set, take the first above the last-grant pointer (round-robin). If none has priority, use round-robin over all requesters.
  - Latch the winner into `OWNER`. Register its `ADDR`/`DATA`/`PEND` into `TX_*` and its priority into `PRIORITY`.
  - Set `TX_REQ`=1, `BUSY`=1, go to `WREQ`.
- `WREQ`:
  - On `TX_ACK`=1: set `REQ_ACK[OWNER]`=1, go to `WACK`.
  - On `TX_FAIL`=1 without ACK: drop `TX_REQ`, go to `WRESP`.
- `WACK`:
  - Wait for `REQ_TX[OWNER]`=0, then drop `TX_REQ`.
  - Once `TX_ACK`=0, drop `REQ_ACK[OWNER]`.
  - If the latched `TX_PEND`=1, go to `WNEXT`; otherwise go to `WRESP`.
- `WNEXT`:
  - On `REQ_TX[OWNER]`=1: register the new word, set `TX_REQ`=1, go to `WREQ`.
  - On `TX_FAIL`=1: go to `WRESP`.
  - Other requesters are ignored; there is no preemption.
- `WRESP`:
  - On `TX_SUCC` or `TX_FAIL`: copy it to `REQ_SUCC`/`REQ_FAIL[OWNER]`, go to `WDONE`.
- `WDONE`:
  - On `REQ_RESP_ACK[OWNER]`=1: set `TX_RESP_ACK`=1.
  - When `TX_SUCC`=`TX_FAIL`=0: clear `REQ_SUCC`/`REQ_FAIL` and `TX_RESP_ACK`.
  - When `REQ_RESP_ACK[OWNER]`=0 as well: last-grant pointer := `OWNER`, `BUSY`=0, go to `IDLE`.
- Simultaneous `TX_SUCC` and `TX_FAIL`: `FAIL` wins.
- `TX_FAIL` takes precedence over `TX_ACK` in the same cycle.
- Requests arriving while `BUSY` wait; they are not dropped.
- `TX_*` outputs hold their last value in `IDLE`.
- Reset mid-operation clears everything immediately, including the node-side `TX_REQ`.
- A requester that deasserts `REQ_TX` before `ACK` in `WREQ` has violated protocol; behaviour is undefined, and the bench flags it with an assertion.

## Timing
- Grant latency: requester raises `REQ_TX` in cycle n; `TX_REQ`/`TX_*` are valid from cycle n+1.
- ACK relay: `TX_ACK` sampled high in cycle n gives `REQ_ACK` high in cycle n+1.
- Completion relay: `TX_SUCC` or `TX_FAIL` in cycle n gives `REQ_SUCC`/`REQ_FAIL` in n+1.
- RESP_ACK relay: `REQ_RESP_ACK` in cycle n gives `TX_RESP_ACK` in n+1.
- All outputs are registered; there are no combinational input-to-output paths.
- Back-to-back messages: at least one `IDLE` cycle between the end of `WDONE` and the next grant.
- Round-robin pointer update takes effect at the `WDONE`→`IDLE` transition.

## Structure
- State encodings and `NUM_REQ` limits go in shared include `include/mbus_tx_arb_def.v`, alongside `ulpb_def.v`, which provides `ADDR_WIDTH`/`DATA_WIDTH`.
- Sub-module `mbus_rr_picker`:
  - Combinational, parameterized by `NUM_REQ`.
  - Inputs: request mask, priority mask, last pointer.
  - Outputs: winner index and valid.
- Top level holds the FSM, the `TX_*` registers and the relay logic.

## Test plan
- Single word: req 2 sends ADDR 0x5A, DATA 0xDEADBEEF, PEND 0 → `TX_REQ` in the next cycle with those values; `TX_SUCC` relayed to `REQ_SUCC[2]` only; `OWNER`=2.
- Round-robin: reqs 0, 1, 3 held high continuously → grant order 0, 1, 3, 0; no requester is granted twice in a row.
- Priority: reqs 0 and 1 high, `REQ_PRIORITY[1]`=1 → 1 is granted first, then 0.
- Burst: req 1 sends 3 words with PEND 1,1,0 while req 0 requests → three `WREQ` cycles for owner 1; req 0 is granted only after 1's `WDONE`.
- Fail: `TX_FAIL` pulsed in `WNEXT` of a burst → `REQ_FAIL[owner]`=1; `TX_RESP_ACK` handshake completes; `BUSY` returns to 0.
- Reset: `RESETn` pulled low in `WREQ` → `TX_REQ`, `REQ_ACK`, `BUSY` are 0 asynchronously; the first grant after release goes to requester 0.

Source files
------------

// File: rtl/mbus_tx_arbiter_pkg.sv
// Shared types and widths for the MBus TX arbiter.
// Node-side word widths mirror the regular node's ADDR/DATA ports.
package mbus_tx_arbiter_pkg;

    localparam int ADDR_WIDTH  = 8;
    localparam int DATA_WIDTH  = 32;
    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WREQ  = 3'd1,
        WACK  = 3'd2,
        WNEXT = 3'd3,
        WRESP = 3'd4,
        WDONE = 3'd5
    } arb_state_t;

endpackage

// File: rtl/mbus_rr_picker.sv
// Combinational priority-then-round-robin winner selection.
// The search starts at the requester just above the last grant.
module mbus_rr_picker
    import mbus_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int OWNER_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     prio_i,
    input  logic [OWNER_WIDTH-1:0] last_i,
    output logic [OWNER_WIDTH-1:0] idx_o,
    output logic                   valid_o
);

    logic [NUM_REQ-1:0]     cand;
    logic [OWNER_WIDTH-1:0] j;

    always_comb begin
        cand    = (|(req_i & prio_i)) ? (req_i & prio_i) : req_i;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = OWNER_WIDTH'((int'(last_i) + k) % NUM_REQ);
            if (!valid_o && cand[j]) begin
                valid_o = 1'b1;
                idx_o   = j;
            end
        end
    end

endmodule

// File: rtl/mbus_tx_arbiter.sv
// Shares one MBus node TX port among NUM_REQ local requesters.
// Owner keeps the grant for the whole message, bursts included.
module mbus_tx_arbiter
    import mbus_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int OWNER_WIDTH = 2
) (
    input  logic                          CLKIN,
    input  logic                          RESETn,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_PEND,
    input  logic [NUM_REQ-1:0]            REQ_TX,
    input  logic [NUM_REQ-1:0]            REQ_PRIORITY,
    output logic [NUM_REQ-1:0]            REQ_ACK,
    output logic [NUM_REQ-1:0]            REQ_SUCC,
    output logic [NUM_REQ-1:0]            REQ_FAIL,
    input  logic [NUM_REQ-1:0]            REQ_RESP_ACK,
    output logic [ADDR_WIDTH-1:0]         TX_ADDR,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_PEND,
    output logic                          TX_REQ,
    output logic                          PRIORITY,
    input  logic                          TX_ACK,
    input  logic                          TX_SUCC,
    input  logic                          TX_FAIL,
    output logic                          TX_RESP_ACK,
    output logic                          BUSY,
    output logic [OWNER_WIDTH-1:0]        OWNER
);

    logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g] = REQ_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_a[g] = REQ_DATA[g*DATA_WIDTH +: DATA_WIDTH];
    end

    arb_state_t             state_q, state_d;
    logic [OWNER_WIDTH-1:0] owner_q, owner_d;
    logic [OWNER_WIDTH-1:0] last_q, last_d;
    logic [ADDR_WIDTH-1:0]  tx_addr_q, tx_addr_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                   tx_pend_q, tx_pend_d;
    logic                   tx_req_q, tx_req_d;
    logic                   prio_q, prio_d;
    logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]     req_succ_q, req_succ_d;
    logic [NUM_REQ-1:0]     req_fail_q, req_fail_d;
    logic                   resp_ack_q, resp_ack_d;
    logic                   busy_q, busy_d;

    logic [OWNER_WIDTH-1:0] win_idx;
    logic                   win_valid;

    mbus_rr_picker #(
        .NUM_REQ     (NUM_REQ),
        .OWNER_WIDTH (OWNER_WIDTH)
    ) u_picker (
        .req_i   (REQ_TX),
        .prio_i  (REQ_PRIORITY),
        .last_i  (last_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= OWNER_WIDTH'(NUM_REQ - 1);
            tx_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_pend_q  <= 1'b0;
            tx_req_q   <= 1'b0;
            prio_q     <= 1'b0;
            req_ack_q  <= '0;
            req_succ_q <= '0;
            req_fail_q <= '0;
            resp_ack_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            tx_addr_q  <= tx_addr_d;
            tx_data_q  <= tx_data_d;
            tx_pend_q  <= tx_pend_d;
            tx_req_q   <= tx_req_d;
            prio_q     <= prio_d;
            req_ack_q  <= req_ack_d;
            req_succ_q <= req_succ_d;
            req_fail_q <= req_fail_d;
            resp_ack_q <= resp_ack_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        tx_addr_d  = tx_addr_q;
        tx_data_d  = tx_data_q;
        tx_pend_d  = tx_pend_q;
        tx_req_d   = tx_req_q;
        prio_d     = prio_q;
        req_ack_d  = req_ack_q;
        req_succ_d = req_succ_q;
        req_fail_d = req_fail_q;
        resp_ack_d = resp_ack_q;
        busy_d     = busy_q;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    owner_d   = win_idx;
                    tx_addr_d = addr_a[win_idx];
                    tx_data_d = data_a[win_idx];
                    tx_pend_d = REQ_PEND[win_idx];
                    prio_d    = REQ_PRIORITY[win_idx];
                    tx_req_d  = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = WREQ;
                end
            end
            WREQ: begin
                if (TX_FAIL) begin
                    tx_req_d = 1'b0;
                    state_d  = WRESP;
                end else if (TX_ACK) begin
                    req_ack_d[owner_q] = 1'b1;
                    state_d            = WACK;
                end
            end
            WACK: begin
                if (!REQ_TX[owner_q]) begin
                    tx_req_d = 1'b0;
                end
                if (!tx_req_q && !TX_ACK) begin
                    req_ack_d[owner_q] = 1'b0;
                    state_d = tx_pend_q ? WNEXT : WRESP;
                end
            end
            WNEXT: begin
                // Only the owner may continue; others wait for IDLE.
                if (TX_FAIL) begin
                    state_d = WRESP;
                end else if (REQ_TX[owner_q]) begin
                    tx_addr_d = addr_a[owner_q];
                    tx_data_d = data_a[owner_q];
                    tx_pend_d = REQ_PEND[owner_q];
                    tx_req_d  = 1'b1;
                    state_d   = WREQ;
                end
            end
            WRESP: begin
                if (TX_FAIL) begin
                    req_fail_d[owner_q] = 1'b1;
                    state_d             = WDONE;
                end else if (TX_SUCC) begin
                    req_succ_d[owner_q] = 1'b1;
                    state_d             = WDONE;
                end
            end
            WDONE: begin
                if (REQ_RESP_ACK[owner_q]) begin
                    resp_ack_d = 1'b1;
                end
                if (!TX_SUCC && !TX_FAIL) begin
                    req_succ_d = '0;
                    req_fail_d = '0;
                    resp_ack_d = 1'b0;
                    if (!REQ_RESP_ACK[owner_q]) begin
                        last_d  = owner_q;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign REQ_ACK     = req_ack_q;
    assign REQ_SUCC    = req_succ_q;
    assign REQ_FAIL    = req_fail_q;
    assign TX_ADDR     = tx_addr_q;
    assign TX_DATA     = tx_data_q;
    assign TX_PEND     = tx_pend_q;
    assign TX_REQ      = tx_req_q;
    assign PRIORITY    = prio_q;
    assign TX_RESP_ACK = resp_ack_q;
    assign BUSY        = busy_q;
    assign OWNER       = owner_q;

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// Directed scoreboard bench for mbus_tx_arbiter.
// The bench plays both the requesters and the MBus node.
module tb_mbus_tx_arbiter;
    import mbus_tx_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int OW = 2;

    logic                     CLKIN;
    logic                     RESETn;
    logic [N*ADDR_WIDTH-1:0]  REQ_ADDR;
    logic [N*DATA_WIDTH-1:0]  REQ_DATA;
    logic [N-1:0]             REQ_PEND;
    logic [N-1:0]             REQ_TX;
    logic [N-1:0]             REQ_PRIORITY;
    logic [N-1:0]             REQ_ACK;
    logic [N-1:0]             REQ_SUCC;
    logic [N-1:0]             REQ_FAIL;
    logic [N-1:0]             REQ_RESP_ACK;
    logic [ADDR_WIDTH-1:0]    TX_ADDR;
    logic [DATA_WIDTH-1:0]    TX_DATA;
    logic                     TX_PEND;
    logic                     TX_REQ;
    logic                     PRIORITY;
    logic                     TX_ACK;
    logic                     TX_SUCC;
    logic                     TX_FAIL;
    logic                     TX_RESP_ACK;
    logic                     BUSY;
    logic [OW-1:0]            OWNER;

    mbus_tx_arbiter #(
        .NUM_REQ     (N),
        .OWNER_WIDTH (OW)
    ) dut (
        .CLKIN        (CLKIN),
        .RESETn       (RESETn),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_DATA     (REQ_DATA),
        .REQ_PEND     (REQ_PEND),
        .REQ_TX       (REQ_TX),
        .REQ_PRIORITY (REQ_PRIORITY),
        .REQ_ACK      (REQ_ACK),
        .REQ_SUCC     (REQ_SUCC),
        .REQ_FAIL     (REQ_FAIL),
        .REQ_RESP_ACK (REQ_RESP_ACK),
        .TX_ADDR      (TX_ADDR),
        .TX_DATA      (TX_DATA),
        .TX_PEND      (TX_PEND),
        .TX_REQ       (TX_REQ),
        .PRIORITY     (PRIORITY),
        .TX_ACK       (TX_ACK),
        .TX_SUCC      (TX_SUCC),
        .TX_FAIL      (TX_FAIL),
        .TX_RESP_ACK  (TX_RESP_ACK),
        .BUSY         (BUSY),
        .OWNER        (OWNER)
    );

    typedef struct packed {
        logic [OW-1:0]         owner;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  pend;
        logic                  prio;
    } rec_t;

    rec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        CLKIN = 1'b0;
        forever #5 CLKIN = ~CLKIN;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // A requester must hold REQ_TX until it sees its ACK.
    always @(negedge CLKIN) begin
        if (RESETn === 1'b1) begin
            assert (!(TX_REQ === 1'b1 && REQ_ACK === '0 &&
                      REQ_TX[OWNER] === 1'b0))
            else begin
                failures++;
                $error("FAIL proto_early_drop observed=REQ_TX low expected=held until ACK");
            end
        end
    end

    task automatic step();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input int i, input logic [7:0] a,
                         input logic [31:0] d, input logic p,
                         input logic pr, input logic front);
        rec_t r;
        REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
        REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH] = d;
        REQ_PEND[i]     = p;
        REQ_PRIORITY[i] = pr;
        REQ_TX[i]       = 1'b1;
        r = '{owner: OW'(i), addr: a, data: d, pend: p, prio: pr};
        // Burst continuation words belong to the current owner: go first.
        if (front) exp_q.push_front(r);
        else exp_q.push_back(r);
    endtask

    task automatic check_grant(input string tag);
        rec_t r;
        int   n;
        n = 0;
        while (TX_REQ !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd1);
        chk({tag, "_busy"}, 64'(BUSY), 64'd1);
        chk({tag, "_sb"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk({tag, "_owner"}, 64'(OWNER), 64'(r.owner));
            chk({tag, "_addr"}, 64'(TX_ADDR), 64'(r.addr));
            chk({tag, "_data"}, 64'(TX_DATA), 64'(r.data));
            chk({tag, "_pend"}, 64'(TX_PEND), 64'(r.pend));
            chk({tag, "_prio"}, 64'(PRIORITY), 64'(r.prio));
        end
    endtask

    task automatic ack_word(input int o);
        TX_ACK = 1'b1;
        step();
        chk("req_ack", 64'(REQ_ACK), 64'(1 << o));
        REQ_TX[o] = 1'b0;
        step();
        chk("tx_req_drop", 64'(TX_REQ), 64'd0);
        TX_ACK = 1'b0;
        step();
        chk("req_ack_drop", 64'(REQ_ACK), 64'd0);
    endtask

    task automatic complete(input int o, input logic fail);
        int n;
        TX_SUCC = !fail;
        TX_FAIL = fail;
        n = 0;
        while ((REQ_SUCC | REQ_FAIL) === '0 && n < 10) begin
            step();
            n++;
        end
        chk("req_succ", 64'(REQ_SUCC), fail ? 64'd0 : 64'(1 << o));
        chk("req_fail", 64'(REQ_FAIL), fail ? 64'(1 << o) : 64'd0);
        REQ_RESP_ACK[o] = 1'b1;
        step();
        chk("tx_resp_ack", 64'(TX_RESP_ACK), 64'd1);
        TX_SUCC = 1'b0;
        TX_FAIL = 1'b0;
        step();
        chk("status_clr", 64'(REQ_SUCC | REQ_FAIL), 64'd0);
        chk("tx_resp_ack_clr", 64'(TX_RESP_ACK), 64'd0);
        REQ_RESP_ACK[o] = 1'b0;
        step();
        chk("busy_clr", 64'(BUSY), 64'd0);
        chk("idle_gap", 64'(TX_REQ), 64'd0);
    endtask

    task automatic clear_inputs();
        REQ_ADDR     = '0;
        REQ_DATA     = '0;
        REQ_PEND     = '0;
        REQ_TX       = '0;
        REQ_PRIORITY = '0;
        REQ_RESP_ACK = '0;
        TX_ACK       = 1'b0;
        TX_SUCC      = 1'b0;
        TX_FAIL      = 1'b0;
    endtask

    initial begin
        clear_inputs();
        RESETn = 1'b0;
        step();
        step();
        RESETn = 1'b1;
        step();
        chk("rst_tx_req", 64'(TX_REQ), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_owner", 64'(OWNER), 64'd0);
        chk("rst_req_vec", 64'({REQ_ACK, REQ_SUCC, REQ_FAIL}), 64'd0);
        chk("rst_tx_word", 64'({TX_ADDR, TX_DATA}), 64'd0);
        chk("rst_misc", 64'({TX_PEND, PRIORITY, TX_RESP_ACK}), 64'd0);

        // Single word from requester 2.
        raise(2, 8'h5A, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        check_grant("single");
        ack_word(2);
        complete(2, 1'b0);
        chk("idle_hold_addr", 64'(TX_ADDR), 64'h5A);
        chk("idle_hold_data", 64'(TX_DATA), 64'hDEAD_BEEF);
        chk("idle_owner", 64'(OWNER), 64'd2);

        // Reset while requester 1 is in WREQ.
        raise(1, 8'h11, 32'h1111_0000, 1'b0, 1'b0, 1'b0);
        check_grant("pre_rst");
        #2;
        RESETn = 1'b0;
        #1;
        chk("async_tx_req", 64'(TX_REQ), 64'd0);
        chk("async_req_ack", 64'(REQ_ACK), 64'd0);
        chk("async_busy", 64'(BUSY), 64'd0);
        clear_inputs();
        step();
        step();
        RESETn = 1'b1;
        step();

        // Round-robin over 0, 1, 3 -> 0, 1, 3, 0.
        raise(0, 8'h20, 32'h0000_0A00, 1'b0, 1'b0, 1'b0);
        raise(1, 8'h21, 32'h0000_0A01, 1'b0, 1'b0, 1'b0);
        raise(3, 8'h23, 32'h0000_0A03, 1'b0, 1'b0, 1'b0);
        check_grant("rr0");
        ack_word(0);
        complete(0, 1'b0);
        raise(0, 8'h30, 32'h0000_0B00, 1'b0, 1'b0, 1'b0);
        check_grant("rr1");
        ack_word(1);
        complete(1, 1'b0);
        check_grant("rr3");
        ack_word(3);
        complete(3, 1'b0);
        check_grant("rr0b");
        ack_word(0);
        complete(0, 1'b0);

        // Burst of three words from 1 while 0 waits.
        raise(1, 8'h41, 32'hB0B0_0001, 1'b1, 1'b0, 1'b0);
        check_grant("burst_w0");
        raise(0, 8'h40, 32'hC0C0_0000, 1'b0, 1'b0, 1'b0);
        ack_word(1);
        raise(1, 8'h42, 32'hB0B0_0002, 1'b1, 1'b0, 1'b1);
        check_grant("burst_w1");
        ack_word(1);
        raise(1, 8'h43, 32'hB0B0_0003, 1'b0, 1'b0, 1'b1);
        check_grant("burst_w2");
        ack_word(1);
        chk("burst_no_preempt", 64'(OWNER), 64'd1);
        complete(1, 1'b0);
        check_grant("after_burst");
        ack_word(0);
        complete(0, 1'b0);

        // Failure raised while waiting for the next burst word.
        raise(1, 8'h51, 32'hFA11_0001, 1'b1, 1'b0, 1'b0);
        check_grant("fail_w0");
        ack_word(1);
        complete(1, 1'b1);

        // Priority beats round-robin (pointer now favours 0).
        raise(1, 8'h61, 32'h9000_0001, 1'b0, 1'b1, 1'b0);
        raise(0, 8'h60, 32'h9000_0000, 1'b0, 1'b0, 1'b0);
        check_grant("prio_first");
        ack_word(1);
        complete(1, 1'b0);
        check_grant("prio_second");
        ack_word(0);
        complete(0, 1'b0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
